lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Device-side end of the 4-signal HD44780-style LCD bus (rw, rs, enable, 8-bit data) that the Nios system drives from its PIOs.
- Decodes instruction and data writes and keeps a 128-byte DDRAM shadow plus an address counter (AC).
- Models the busy flag and answers status and data reads.
- Used in place of the physical panel for simulation and on-chip self-check, and as a bus monitor; the shadow is readable through a side port.

Parameters:
- BUSY_CYCLES, 2000, busy duration after a normal instruction or data write (40 us at 50 MHz).
- CLEAR_CYCLES, 82000, busy duration after Clear Display or Return Home (1.64 ms at 50 MHz); must be >= 130.
- SYNC_STAGES, 2, synchronizer depth on all bus inputs (minimum 2).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- lcd_enable  in  1  bus E strobe.
- lcd_rs  in  1  register select: 0 = instruction/status, 1 = data.
- lcd_rw  in  1  1 = read, 0 = write.
- lcd_data_in  in  8  bus data driven by the host.
- lcd_data_out  out  8  read-back data.
- lcd_data_oe  out  1  high while the responder drives the bus.
- busy  out  1  busy flag (BF).
- addr_counter  out  7  current AC.
- cmd_valid  out  1  one-cycle pulse per accepted write.
- cmd_rs  out  1  rs of the accepted write.
- cmd_byte  out  8  byte of the accepted write.
- overrun  out  1  sticky: an access occurred while busy.
- shadow_addr  in  7  side-port DDRAM read address.
- shadow_data  out  8  DDRAM[shadow_addr], registered, 1-cycle latency.

Behaviour:
Interface rules
- Clock is clk_clk; reset is reset_reset_n, asynchronous assert, active low.
- All bus inputs pass through SYNC_STAGES flops. Edge detection uses the synchronized E.
- Reset values: every output is 0 except cmd_byte=0x00 and addr_counter=0. ID (increment) resets to 1. DDRAM contents are undefined until the first Clear.

Writes
- Accepted on the falling edge of synced E with synced rw=0, using the rs/data sampled in the cycle before the fall.
- cmd_valid pulses the cycle after the fall.
- If busy=1 at the fall: the write is ignored, overrun is set, and no cmd_valid is produced.

Instruction decode (rs=0), highest set bit wins:
- 1xxxxxxx: AC = data[6:0].
- 01xxxxxx: CGRAM address. AC unchanged; the write is accepted and produces cmd_valid only.
- 001xxxxx / 00001xxx: function set / display control. Stored for nothing; cmd_valid only.
- 000001IS: ID = I. S is ignored.
- 0000001x: Return Home. AC = 0. Busy for CLEAR_CYCLES.
- 00000001: Clear. AC = 0, ID = 1. A sweep counter writes 0x20 into DDRAM[0..127], one location per cycle, starting the cycle after acceptance. Busy for CLEAR_CYCLES.
- 00000000: no-op, BUSY_CYCLES.
- Every other accepted instruction: busy for BUSY_CYCLES.

Data write (rs=1)
- DDRAM[AC] = data.
- AC = AC+1 if ID=1, otherwise AC-1. Wraps modulo 128 (127+1 -> 0, 0-1 -> 127).
- Busy for BUSY_CYCLES.

Busy timer
- Loaded at acceptance; busy=1 from the cycle after acceptance.
- Decrements each cycle; busy drops in the cycle the counter reaches 0.
- Total busy duration is exactly the parameter value in cycles.

Reads
- lcd_data_oe = synced E & synced rw.
- rs=0: lcd_data_out = {busy, AC}, updated every cycle while oe=1.
- rs=1: lcd_data_out = DDRAM[AC]. On the falling edge of E, AC post-steps per ID and busy loads BUSY_CYCLES.
- A data read while busy sets overrun, and AC is not stepped.
- When oe=0, lcd_data_out = 0x00.

Simultaneous events
- A shadow-port read during a Clear sweep returns old or new data for a location being written that cycle; both are legal.
- The sweep has priority over nothing else, because bus writes are rejected while busy.

Other boundary conditions
- rs/rw changing while E is high: sampled values at the fall apply.
- Reset mid-sweep or mid-busy: busy, AC and the timer return to their reset values immediately, and the sweep aborts.

Decomposition:
- Package lcd_bus_pkg holds:
  - instruction opcode masks/constants: CLEAR=8'h01, HOME_MASK, ENTRY_MASK, DDRAM_MASK, CGRAM_MASK;
  - the space character 8'h20;
  - a typedef for the decoded-instruction enum: OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_CTRL, OP_CGRAM, OP_DDRAM, OP_DATA.
- One sub-module, lcd_bus_sync: the SYNC_STAGES synchronizer plus E falling/rising-edge detect.
- Decode, AC, busy timer, sweep and DDRAM stay in the top.

Test Plan:
- Reset, then Clear (rs=0, 0x01), wait CLEAR_CYCLES -> busy high for exactly 82000 cycles; shadow_data=0x20 at addresses 0, 64 and 127; AC=0.
- Set address 0x80|0x7E, then three data writes 'A','B','C' spaced by BUSY_CYCLES -> DDRAM[7E]=0x41, DDRAM[7F]=0x42, DDRAM[00]=0x43; AC=1 (increment wrap).
- Entry mode 0x04 (ID=0), set AC=0x00, write 'Z' -> DDRAM[00]=0x5A, AC=127.
- Status read with rs=0, rw=1 immediately after a data write -> lcd_data_out=0x80|AC, oe=1 only while E is high; after 2000 cycles, bit 7 reads 0.
- Data write issued 10 cycles after a prior write -> no cmd_valid, DDRAM unchanged, overrun=1 and held until reset.
- Clear, assert reset_reset_n=0 at cycle 50 of the sweep -> busy=0, AC=0, overrun=0 asynchronously; after release, a new write is accepted normally.

Source files
------------

// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the LCD bus responder: instruction masks,
// fill character and the decoded-instruction type.
package lcd_bus_pkg;

  localparam int unsigned DDRAM_DEPTH = 128;

  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME_MASK  = 8'h02;
  localparam logic [7:0] ENTRY_MASK = 8'h04;
  localparam logic [7:0] CTRL_MASK  = 8'h38;
  localparam logic [7:0] CGRAM_MASK = 8'h40;
  localparam logic [7:0] DDRAM_MASK = 8'h80;
  localparam logic [7:0] SPACE      = 8'h20;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_CTRL,
    OP_CGRAM,
    OP_DDRAM,
    OP_DATA
  } op_t;

  // Highest set bit of an instruction byte selects the operation.
  function automatic op_t decode_op(input logic rs, input logic [7:0] b);
    if (rs)                      return OP_DATA;
    if ((b & DDRAM_MASK) != '0)  return OP_DDRAM;
    if ((b & CGRAM_MASK) != '0)  return OP_CGRAM;
    if ((b & CTRL_MASK) != '0)   return OP_CTRL;
    if ((b & ENTRY_MASK) != '0)  return OP_ENTRY;
    if ((b & HOME_MASK) != '0)   return OP_HOME;
    if (b == CLEAR)              return OP_CLEAR;
    return OP_NOP;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Bus input synchronizer with E falling-edge detect.
// Ports: clk/rst_n; raw e/rs/rw/data in; synced e/rs/rw out;
// fall = synced E high->low; *_prev = synced values of the previous cycle.
module lcd_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e_in,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [7:0] data_in,
  output logic       e,
  output logic       rs,
  output logic       rw,
  output logic       fall,
  output logic       rs_prev,
  output logic       rw_prev,
  output logic [7:0] data_prev
);

  localparam int unsigned W = 11;

  logic [SYNC_STAGES-1:0][W-1:0] chain;
  logic [W-1:0]                  held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      held  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], {e_in, rs_in, rw_in, data_in}};
      held  <= chain[SYNC_STAGES-1];
    end
  end

  assign {e, rs, rw} = chain[SYNC_STAGES-1][10:8];

  // held carries the bus values of the last cycle E was still high.
  assign fall      = held[10] & ~e;
  assign rs_prev   = held[9];
  assign rw_prev   = held[8];
  assign data_prev = held[7:0];

endmodule

// File: rtl/lcd_bus_responder.sv
// Device-side HD44780-style bus responder: decodes writes, keeps a
// 128-byte DDRAM shadow and address counter, models the busy flag and
// answers status/data reads. Shadow readable through shadow_addr/data.
// Ports: clk_clk, reset_reset_n; lcd_enable/rs/rw/data_in bus inputs;
// lcd_data_out/oe read-back; busy, addr_counter, cmd_* write monitor,
// overrun sticky flag; shadow_addr/shadow_data side port (1-cycle).
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       lcd_enable,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic [6:0] addr_counter,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic       overrun,
  input  logic [6:0] shadow_addr,
  output logic [7:0] shadow_data
);

  localparam int unsigned TMAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_BUSY  = TW'(BUSY_CYCLES);
  localparam logic [TW-1:0] T_CLEAR = TW'(CLEAR_CYCLES);

  logic       e_s, rs_s, rw_s, e_fall, rs_p, rw_p;
  logic [7:0] data_p;

  logic [7:0]    ddram [DDRAM_DEPTH];
  logic [TW-1:0] timer;
  logic [6:0]    ac;
  logic          id;
  logic          sweep_active;
  logic [6:0]    sweep_addr;

  op_t        op;
  logic       wr_accept, rd_step, busy_hit;
  logic [6:0] ac_step;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;

  lcd_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .e_in      (lcd_enable),
    .rs_in     (lcd_rs),
    .rw_in     (lcd_rw),
    .data_in   (lcd_data_in),
    .e         (e_s),
    .rs        (rs_s),
    .rw        (rw_s),
    .fall      (e_fall),
    .rs_prev   (rs_p),
    .rw_prev   (rw_p),
    .data_prev (data_p)
  );

  assign busy         = (timer != '0);
  assign addr_counter = ac;
  assign lcd_data_oe  = e_s & rw_s;

  always_comb begin
    op        = decode_op(rs_p, data_p);
    wr_accept = e_fall & ~rw_p & ~busy;
    rd_step   = e_fall & rw_p & rs_p & ~busy;
    busy_hit  = e_fall & busy & (~rw_p | rs_p);
    ac_step   = id ? ac + 7'd1 : ac - 7'd1;
    // Sweep and bus data writes never coincide: bus writes are refused while busy.
    mem_we    = sweep_active | (wr_accept & rs_p);
    mem_addr  = sweep_active ? sweep_addr : ac;
    mem_wdata = sweep_active ? SPACE : data_p;
  end

  always_comb begin
    lcd_data_out = '0;
    if (lcd_data_oe) begin
      lcd_data_out = rs_s ? ddram[ac] : {busy, ac};
    end
  end

  always_ff @(posedge clk_clk) begin
    if (mem_we) begin
      ddram[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shadow_data <= '0;
    end else begin
      shadow_data <= ddram[shadow_addr];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      timer        <= '0;
      ac           <= '0;
      id           <= 1'b1;
      sweep_active <= 1'b0;
      sweep_addr   <= '0;
      overrun      <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_rs       <= 1'b0;
      cmd_byte     <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (busy) begin
        timer <= timer - TW'(1);
      end
      if (sweep_active) begin
        sweep_addr <= sweep_addr + 7'd1;
        if (sweep_addr == 7'd127) begin
          sweep_active <= 1'b0;
        end
      end
      if (busy_hit) begin
        overrun <= 1'b1;
      end
      if (wr_accept) begin
        cmd_valid <= 1'b1;
        cmd_rs    <= rs_p;
        cmd_byte  <= data_p;
        timer     <= T_BUSY;
        unique case (op)
          OP_DATA:  ac <= ac_step;
          OP_DDRAM: ac <= data_p[6:0];
          OP_ENTRY: id <= data_p[1];
          OP_HOME: begin
            ac    <= '0;
            timer <= T_CLEAR;
          end
          OP_CLEAR: begin
            ac           <= '0;
            id           <= 1'b1;
            timer        <= T_CLEAR;
            sweep_active <= 1'b1;
            sweep_addr   <= '0;
          end
          default: ;
        endcase
      end else if (rd_step) begin
        ac    <= ac_step;
        timer <= T_BUSY;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed plus randomized bench for lcd_bus_responder with a
// behavioural DDRAM/AC/busy model.
module tb_lcd_bus_responder;

  localparam int unsigned BUSY_N  = 40;
  localparam int unsigned CLEAR_N = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_enable, lcd_rs, lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe, busy, cmd_valid, cmd_rs, overrun;
  logic [6:0] addr_counter, shadow_addr;
  logic [7:0] cmd_byte, shadow_data;

  lcd_bus_responder #(
    .BUSY_CYCLES (BUSY_N),
    .CLEAR_CYCLES(CLEAR_N),
    .SYNC_STAGES (2)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .lcd_enable   (lcd_enable),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .busy         (busy),
    .addr_counter (addr_counter),
    .cmd_valid    (cmd_valid),
    .cmd_rs       (cmd_rs),
    .cmd_byte     (cmd_byte),
    .overrun      (overrun),
    .shadow_addr  (shadow_addr),
    .shadow_data  (shadow_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mem [128];
  int m_ac;
  bit m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input bit rs, input logic [7:0] d, output int dur);
    int top;
    dur = BUSY_N;
    if (rs) begin
      m_mem[m_ac] = d;
      m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
      return;
    end
    top = -1;
    for (int i = 0; i < 8; i++) if (d[i]) top = i;
    case (top)
      7: m_ac = int'(d[6:0]);
      2: m_id = d[1];
      1: begin m_ac = 0; dur = CLEAR_N; end
      0: begin
        m_ac = 0;
        m_id = 1'b1;
        foreach (m_mem[i]) m_mem[i] = 32'h20;
        dur = CLEAR_N;
      end
      default: ;
    endcase
  endtask

  task automatic bus_access(input bit rs, input bit rw, input logic [7:0] d, input int hold);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_enable = 1'b1;
    repeat (hold) @(negedge clk);
    lcd_enable = 1'b0;
  endtask

  task automatic accept_check(input bit rs, input logic [7:0] d, output int t_acc, output int dur);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (cmd_valid) seen = 1'b1;
    end
    check("cmd_valid", seen, 1);
    t_acc = cyc;
    check("cmd_rs", cmd_rs, rs);
    check("cmd_byte", cmd_byte, d);
    model_write(rs, d, dur);
    check("ac_after_write", addr_counter, m_ac);
    check("busy_start", busy, 1);
    @(negedge clk);
    check("cmd_pulse_width", cmd_valid, 0);
  endtask

  task automatic write_start(input bit rs, input logic [7:0] d, output int t_acc, output int dur);
    bus_access(rs, 1'b0, d, 4);
    accept_check(rs, d, t_acc, dur);
  endtask

  task automatic busy_window(input int t_acc, input int dur);
    while (cyc < t_acc + dur - 1) @(negedge clk);
    check("busy_last_cycle", busy, 1);
    @(negedge clk);
    check("busy_dropped", busy, 0);
  endtask

  task automatic write_full(input bit rs, input logic [7:0] d);
    int t, dur;
    write_start(rs, d, t, dur);
    busy_window(t, dur);
  endtask

  task automatic shadow_check(input logic [6:0] a, input int exp);
    @(negedge clk);
    shadow_addr = a;
    @(negedge clk);
    check($sformatf("shadow[%0d]", a), shadow_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int t0, dur, r;
    bit seen;
    bit rs;
    logic [7:0] d;
    logic [6:0] a;

    rst_n = 1'b0;
    lcd_enable = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = '0;
    shadow_addr = '0;
    m_ac = 0; m_id = 1'b1;
    foreach (m_mem[i]) m_mem[i] = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_ac", addr_counter, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_rs", cmd_rs, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_overrun", overrun, 0);
    check("rst_oe", lcd_data_oe, 0);
    check("rst_data_out", lcd_data_out, 0);
    check("rst_shadow", shadow_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clear: exact busy length, DDRAM filled with spaces
    write_full(1'b0, 8'h01);
    shadow_check(7'd0, 32'h20);
    shadow_check(7'd64, 32'h20);
    shadow_check(7'd127, 32'h20);
    check("clear_ac", addr_counter, 0);

    // Set address 0x7E, write A B C with increment wrap
    write_full(1'b0, 8'hFE);
    write_full(1'b1, 8'h41);
    write_full(1'b1, 8'h42);
    write_full(1'b1, 8'h43);
    shadow_check(7'h7E, 32'h41);
    shadow_check(7'h7F, 32'h42);
    shadow_check(7'h00, 32'h43);
    check("ac_inc_wrap", addr_counter, 1);

    // Decrement mode with wrap below zero
    write_full(1'b0, 8'h04);
    write_full(1'b0, 8'h80);
    write_full(1'b1, 8'h5A);
    shadow_check(7'h00, 32'h5A);
    check("ac_dec_wrap", addr_counter, 127);

    // Status read while busy right after a data write
    write_start(1'b1, 8'h51, t0, dur);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("status_oe", lcd_data_oe, 1);
    check("status_busy", lcd_data_out, 32'h80 | m_ac);
    lcd_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("status_oe_off", lcd_data_oe, 0);
    check("data_out_idle", lcd_data_out, 0);
    busy_window(t0, dur);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("status_idle", lcd_data_out, m_ac);
    lcd_enable = 1'b0;
    repeat (3) @(negedge clk);

    // Return Home uses the long busy time; no-op uses the short one
    write_full(1'b0, 8'h02);
    write_full(1'b0, 8'h00);
    write_full(1'b0, 8'h06);

    // Data read: returns DDRAM[AC], then AC post-steps and busy loads
    write_full(1'b0, 8'hFE);
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_oe", lcd_data_oe, 1);
    check("rd_data", lcd_data_out, m_mem[m_ac]);
    lcd_enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("rd_busy", seen, 1);
    t0 = cyc;
    m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
    check("rd_ac_step", addr_counter, m_ac);
    busy_window(t0, BUSY_N);
    check("rd_no_overrun", overrun, 0);

    // rs/rw change while E is high: values at the fall apply
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_data_in = 8'h00; lcd_enable = 1'b1;
    repeat (2) @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h85;
    repeat (3) @(negedge clk);
    lcd_enable = 1'b0;
    accept_check(1'b0, 8'h85, t0, dur);
    busy_window(t0, dur);

    // Randomized writes against the model
    repeat (24) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        rs = 1'b1; d = 8'($urandom_range(32, 126));
      end else if (r < 8) begin
        rs = 1'b0; d = 8'h80 | 8'($urandom_range(0, 127));
      end else if (r == 8) begin
        rs = 1'b0; d = 8'h04 | 8'($urandom_range(0, 3));
      end else begin
        rs = 1'b0; d = 8'h08 | 8'($urandom_range(0, 7));
      end
      write_full(rs, d);
    end
    repeat (8) begin
      a = 7'($urandom_range(0, 127));
      shadow_check(a, m_mem[a]);
    end

    // Write during busy is refused and sets sticky overrun
    write_start(1'b1, 8'h58, t0, dur);
    while (cyc < t0 + 10) @(negedge clk);
    bus_access(1'b1, 1'b0, 8'h59, 4);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_valid) seen = 1'b1;
    end
    check("busy_write_ignored", seen, 0);
    check("overrun_set", overrun, 1);
    check("busy_write_ac", addr_counter, m_ac);
    busy_window(t0, dur);
    shadow_check(7'(m_ac), m_mem[m_ac]);
    write_full(1'b0, 8'h0C);
    check("overrun_sticky", overrun, 1);

    // Reset in the middle of a Clear sweep
    write_start(1'b0, 8'h01, t0, dur);
    while (cyc < t0 + 50) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ac", addr_counter, 0);
    check("midrst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ac = 0; m_id = 1'b1;
    write_full(1'b1, 8'h4B);
    shadow_check(7'd0, 32'h4B);
    check("post_rst_ac", addr_counter, 1);
    check("post_rst_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
